// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial sequence detector: FSM encoding,
// default sizing and the pattern-length mask helper.
package seq_det_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int PAT_MAX_DEF = 8;
  localparam int CNT_W_DEF   = 4;
  localparam int MASK_W      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Low 'len' bits set; callers truncate to their pattern width.
  function automatic logic [MASK_W-1:0] len_mask(input logic [31:0] len);
    logic [MASK_W-1:0] m;
    if (len >= 32'(MASK_W)) begin
      m = '1;
    end else begin
      m = (32'd1 << len) - 32'd1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_match.sv
// Bit-history shift register, valid-bit counter and masked comparator.
// 'hit' is the unregistered verdict for the bit being shifted in this cycle.
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic               bit_in,
  input  logic [PAT_MAX-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               match,
  output logic               hit
);

  logic [PAT_MAX-1:0] hist_q, hist_d;
  logic [PAT_MAX-1:0] mask_s;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               match_q, hit_s;

  assign mask_s = PAT_MAX'(len_mask(32'(len)));

  // Next history/count and the match verdict on that next state.
  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    hit_s  = 1'b0;
    if (clr) begin
      hist_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      hist_d = {hist_q[PAT_MAX-2:0], bit_in};
      if (cnt_q != LEN_W'(PAT_MAX)) begin
        cnt_d = cnt_q + LEN_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
      hit_s = (len != '0) && (cnt_d >= len) && (((hist_d ^ pattern) & mask_s) == '0);
    end else begin
      hist_d = hist_q;
      cnt_d  = cnt_q;
    end
  end

  // History, count and registered match pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      match_q <= hit_s;
    end
  end

  assign match = match_q;
  assign hit   = hit_s;

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-framed controller: accepts a parallel word, shifts it out MSB first
// through the matcher and reports per-word saturating match counts.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  localparam int LEN_W  = $clog2(PAT_MAX + 1),
  localparam int IDX_W  = $clog2(DATA_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               busy,
  output logic               bit_valid,
  output logic               bit_out,
  output logic               match,
  output logic               done,
  output logic [CNT_W-1:0]   match_count
);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [PAT_MAX-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept_s, shift_s, bit_s, hit_s, match_s;

  // Readiness uses the state alone so an asserted reset cannot feed the accept path.
  assign accept_s = in_valid && (state_q == IDLE);
  assign shift_s  = (state_q == SHIFT);
  assign bit_s    = word_q[idx_q];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept_s ? SHIFT : IDLE;
      SHIFT:   state_d = (idx_q == '0) ? DONE : SHIFT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    bit_valid = 1'b0;
    bit_out   = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: in_ready = ~rst;
      SHIFT: begin
        busy      = 1'b1;
        bit_valid = 1'b1;
        bit_out   = bit_s;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Config latch, word capture, bit index and saturating match count.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    pat_d  = pat_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    if ((state_q == IDLE) && cfg_we) begin
      pat_d = cfg_pattern;
      len_d = (cfg_len > LEN_W'(PAT_MAX)) ? LEN_W'(PAT_MAX) : cfg_len;
    end else begin
      pat_d = pat_q;
      len_d = len_q;
    end
    if (accept_s) begin
      word_d = in_data;
      idx_d  = IDX_W'(DATA_W - 1);
      cnt_d  = '0;
    end else if (shift_s) begin
      idx_d = (idx_q != '0) ? (idx_q - IDX_W'(1)) : idx_q;
      cnt_d = (hit_s && (cnt_q != '1)) ? (cnt_q + CNT_W'(1)) : cnt_q;
    end else begin
      idx_d = idx_q;
      cnt_d = cnt_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      idx_q  <= '0;
      pat_q  <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
    end
  end

  seq_det_match #(
    .PAT_MAX (PAT_MAX),
    .LEN_W   (LEN_W)
  ) u_match (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept_s),
    .shift_en (shift_s),
    .bit_in   (bit_s),
    .pattern  (pat_q),
    .len      (len_q),
    .match    (match_s),
    .hit      (hit_s)
  );

  assign match       = match_s;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed vector table, reset abort
// sequence and randomized words against a pattern-search reference model.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = 8'h00;
  logic [3:0] cfg_len = 4'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       in_ready_a, busy_a, bv_a, bo_a, match_a, done_a;
  logic [3:0] mc_a;
  logic       in_ready_b, busy_b, bv_b, bo_b, match_b, done_b;
  logic [1:0] mc_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_pat = 8'h00;
  logic [3:0] m_len = 4'd0;

  seq_det_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .busy(busy_a),
    .bit_valid(bv_a), .bit_out(bo_a), .match(match_a), .done(done_a), .match_count(mc_a)
  );

  seq_det_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .busy(busy_b),
    .bit_valid(bv_b), .bit_out(bo_b), .match(match_b), .done(done_b), .match_count(mc_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit m[c] set when a match pulse is expected in cycle c after the accept edge.
  function automatic logic [10:0] model_hits(input logic [7:0] w, input logic [7:0] p,
                                             input logic [3:0] l_raw);
    int l;
    bit ok;
    logic [10:0] m;
    l = (l_raw > 4'd8) ? 8 : int'(l_raw);
    m = '0;
    for (int c = 1; c <= 8; c++) begin
      if (l != 0 && c >= l) begin
        ok = 1'b1;
        for (int j = 0; j < l; j++) begin
          if (w[8 - (c - j)] != p[j]) ok = 1'b0;
        end
        if (ok) m[c + 1] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic int sat(input int n, input int w);
    return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
  endfunction

  // Called at a negedge of an IDLE cycle; returns at the negedge of cycle 10.
  // mode 1 = config write in SHIFT cycle 3, mode 2 = random noise on inputs during the word.
  task automatic run_word(input string tag, input logic [7:0] w, input logic do_cfg,
                          input logic [7:0] p, input logic [3:0] l, input int mode,
                          input int exp_final);
    logic [10:0] m;
    logic [5:0]  ev;
    int          acc;
    if (do_cfg) begin
      cfg_we = 1'b1; cfg_pattern = p; cfg_len = l;
      m_pat = p; m_len = l;
    end
    in_valid = 1'b1;
    in_data  = w;
    chk({tag, " accept_ready"}, 32'(in_ready_a), 32'd1);
    m = model_hits(w, m_pat, m_len);
    @(negedge clk);
    cfg_we = 1'b0;
    in_valid = 1'b0;
    acc = 0;
    for (int c = 1; c <= 10; c++) begin
      if (m[c]) acc++;
      ev = {c == 10, c <= 9, c <= 8, (c <= 8) ? w[8 - c] : 1'b0, m[c], c == 9};
      chk($sformatf("%s c%0d ctl_a", tag, c), 32'({in_ready_a, busy_a, bv_a, bo_a, match_a, done_a}), 32'(ev));
      chk($sformatf("%s c%0d ctl_b", tag, c), 32'({in_ready_b, busy_b, bv_b, bo_b, match_b, done_b}), 32'(ev));
      chk($sformatf("%s c%0d cnt_a", tag, c), 32'(mc_a), sat(acc, 4));
      chk($sformatf("%s c%0d cnt_b", tag, c), 32'(mc_b), sat(acc, 2));
      if (c == 9 && exp_final >= 0) chk({tag, " final_cnt"}, 32'(mc_a), exp_final);
      if (c < 10) begin
        if (mode == 1) begin
          cfg_we = (c == 3); cfg_pattern = 8'h00; cfg_len = 4'd3;
        end else if (mode == 2) begin
          in_valid = 1'($urandom_range(0, 1));
          in_data = 8'($urandom);
          cfg_we = 1'($urandom_range(0, 1));
          cfg_pattern = 8'($urandom);
          cfg_len = 4'($urandom);
        end
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    cfg_we = 1'b0;
  endtask

  typedef struct {
    logic       do_cfg;
    logic [7:0] pat;
    logic [3:0] len;
    logic [7:0] word;
    int         mode;
    int         exp_cnt;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 8'h0B, 4'd4,  8'hB6, 0, 2};
    tbl[1] = '{1'b1, 8'h03, 4'd2,  8'hFF, 0, 7};
    tbl[2] = '{1'b1, 8'hFF, 4'd0,  8'hA5, 0, 0};
    tbl[3] = '{1'b1, 8'h01, 4'd1,  8'hFF, 0, 8};
    tbl[4] = '{1'b1, 8'h0B, 4'd4,  8'hB6, 1, 2};
    tbl[5] = '{1'b1, 8'h00, 4'd3,  8'h80, 0, 5};
    tbl[6] = '{1'b1, 8'h0B, 4'd4,  8'h01, 0, 0};
    tbl[7] = '{1'b0, 8'h00, 4'd0,  8'h60, 0, 0};
    tbl[8] = '{1'b1, 8'hFF, 4'd15, 8'hFF, 0, 1};

    #2;
    chk("rst_ctl_a", 32'({in_ready_a, busy_a, bv_a, bo_a, match_a, done_a}), 32'd0);
    chk("rst_cnt_a", 32'(mc_a), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'(in_ready_a), 32'd1);
    chk("rst_release_busy", 32'(busy_a), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_word($sformatf("vec%0d", i), tbl[i].word, tbl[i].do_cfg, tbl[i].pat,
               tbl[i].len, tbl[i].mode, tbl[i].exp_cnt);
    end

    // Abort a word with an asynchronous reset in SHIFT cycle 4.
    cfg_we = 1'b1; cfg_pattern = 8'h0B; cfg_len = 4'd4;
    in_valid = 1'b1; in_data = 8'hB6;
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ctl_a", 32'({in_ready_a, busy_a, bv_a, bo_a, match_a, done_a}), 32'd0);
    chk("abort_ctl_b", 32'({in_ready_b, busy_b, bv_b, bo_b, match_b, done_b}), 32'd0);
    chk("abort_cnt_a", 32'(mc_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_pat = 8'h00; m_len = 4'd0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("abort_idle%0d", i), 32'({in_ready_a, busy_a, done_a}), 32'b100);
      @(negedge clk);
    end
    run_word("post_rst_nocfg", 8'hB6, 1'b0, 8'h00, 4'd0, 0, 0);
    run_word("post_rst_cfg", 8'hB6, 1'b1, 8'h0B, 4'd4, 0, 2);

    for (int k = 0; k < 40; k++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk($sformatf("rnd%0d gap_ready", k), 32'(in_ready_a), 32'd1);
      end
      run_word($sformatf("rnd%0d", k), 8'($urandom), 1'($urandom_range(0, 1)),
               8'($urandom), 4'($urandom), 2, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
